// File: rtl/heartaware_sp_pkg.sv
// Shared types and constants for the match-filter sequencer: FSM encoding,
// default template length, sample/coefficient widths and the idle index code.
package heartaware_sp_pkg;

    localparam int DATA_W   = 9;
    localparam int COEF_W   = 9;
    localparam int TAPS_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Index value parked on the filter while not sweeping (last tap).
    function automatic int idle_code(input int taps);
        return taps - 1;
    endfunction

    localparam int IDLE_IDX = idle_code(TAPS_DEF);

endpackage

// File: rtl/mf_template_ram.sv
// Template coefficient store: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded template survives reset.
module mf_template_ram
    import heartaware_sp_pkg::*;
#(
    parameter int DEPTH = TAPS_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [COEF_W-1:0] rdata
);

    logic signed [COEF_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/match_filter_sequencer.sv
// Sequencer for a TAPS-long match filter: latches a sample, sweeps the tap
// index across the template, drains, then advances the circular write pointer.
module match_filter_sequencer
    import heartaware_sp_pkg::*;
#(
    parameter int TAPS  = IDLE_IDX + 1,
    parameter int DRAIN = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic                       tpl_we,
    input  logic [$clog2(TAPS)-1:0]    tpl_addr,
    input  logic signed [COEF_W-1:0]   tpl_data,
    output logic                       tpl_ack,
    output logic                       ready,
    output logic signed [DATA_W-1:0]   x,
    output logic [$clog2(TAPS)-1:0]    index,
    output logic [$clog2(TAPS)-1:0]    offset,
    output logic signed [COEF_W-1:0]   coeff_mf,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int IDX_W = $clog2(TAPS);
    localparam int DRN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [IDX_W-1:0] IDLE_CODE = IDX_W'(idle_code(TAPS));
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TAPS - 2);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN - 1);
    localparam logic [DRN_W-1:0] DRN_ONE   = DRN_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              sweep_end;
    logic              drain_end;
    logic              tick_accept;
    logic              we_accept;

    assign sweep_end   = (state == ST_SWEEP) && (index == LAST_IDX);
    assign drain_end   = (state == ST_DRAIN) && (drain_cnt == DRN_LAST);
    // The final drain cycle already counts as idle for an incoming tick.
    assign tick_accept = sample_tick && ((state == ST_IDLE) || drain_end);
    // Holding off while tpl_ack is high keeps the ack a strict single-cycle pulse.
    assign we_accept   = tpl_we && !busy && !tpl_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sample_tick) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SWEEP;
            ST_SWEEP: if (sweep_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_nxt = sample_tick ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        ready = (state == ST_LOAD);
        done  = drain_end;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index     <= IDLE_CODE;
            offset    <= '0;
            drain_cnt <= '0;
            x         <= '0;
            overrun   <= 1'b0;
            tpl_ack   <= 1'b0;
        end else begin
            tpl_ack <= we_accept;

            if (tick_accept) begin
                x <= x_in;
            end

            if (sample_tick && !tick_accept) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_LOAD:  index <= '0;
                ST_SWEEP: index <= sweep_end ? IDLE_CODE : index + IDX_ONE;
                default:  index <= IDLE_CODE;
            endcase

            if ((state == ST_DRAIN) && !drain_end) begin
                drain_cnt <= drain_cnt + DRN_ONE;
            end else begin
                drain_cnt <= '0;
            end

            if (drain_end) begin
                offset <= (offset == IDLE_CODE) ? '0 : offset + IDX_ONE;
            end
        end
    end

    mf_template_ram #(
        .DEPTH (TAPS),
        .AW    (IDX_W)
    ) u_template (
        .clock (clock),
        .we    (we_accept),
        .waddr (tpl_addr),
        .wdata (tpl_data),
        .raddr (index),
        .rdata (coeff_mf)
    );

endmodule

// File: tb/tb_match_filter_sequencer.sv
// Directed bench for match_filter_sequencer: a template model and queues of
// expected sample/coefficient values are compared as the DUT sweeps.
module tb_match_filter_sequencer;

    logic              clock = 1'b0;
    logic              reset;
    logic              sample_tick;
    logic signed [8:0] x_in;
    logic              tpl_we;
    logic [6:0]        tpl_addr;
    logic signed [8:0] tpl_data;
    logic              tpl_ack;
    logic              ready;
    logic signed [8:0] x;
    logic [6:0]        index;
    logic [6:0]        offset;
    logic signed [8:0] coeff_mf;
    logic              busy;
    logic              done;
    logic              overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int off    = 0;

    logic signed [8:0] model [128];
    logic signed [8:0] x_q [$];
    logic signed [8:0] c_q [$];

    match_filter_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .sample_tick (sample_tick),
        .x_in        (x_in),
        .tpl_we      (tpl_we),
        .tpl_addr    (tpl_addr),
        .tpl_data    (tpl_data),
        .tpl_ack     (tpl_ack),
        .ready       (ready),
        .x           (x),
        .index       (index),
        .offset      (offset),
        .coeff_mf    (coeff_mf),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_index", index, 127);
        check("rst_offset", offset, 0);
        check("rst_x", x, 0);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_ack", tpl_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        off = 0;
        check_reset_state();
    endtask

    // One full sweep from a tick in idle. extra_kind 0 = extra tick at
    // cycle extra_at, 1 = template write at cycle extra_at (while busy).
    task automatic sweep(input logic signed [8:0] xv, input int extra_at, input int extra_kind,
                         input logic signed [8:0] extra_x, input bit do_we,
                         input logic [6:0] wa, input logic signed [8:0] wd);
        int c;
        int done_cyc;
        if (do_we) model[wa] = wd;
        x_q.push_back(xv);
        for (int i = 0; i < 127; i++) c_q.push_back(model[i]);
        x_in        = xv;
        sample_tick = 1'b1;
        tpl_we      = do_we;
        tpl_addr    = wa;
        tpl_data    = wd;
        step();
        tpl_we = 1'b0;
        if (do_we) check("ack_with_tick", tpl_ack, 1);
        c        = 1;
        done_cyc = -1;
        while (c < 200 && done_cyc < 0) begin
            sample_tick = (c == extra_at) && (extra_kind == 0);
            tpl_we      = (c == extra_at) && (extra_kind == 1);
            x_in        = (c == extra_at) ? extra_x : xv;
            if (extra_kind == 1 && c == extra_at + 1) check("ack_while_busy", tpl_ack, 0);
            if (ready) begin
                check("ready_cycle", c, 1);
                check("ready_offset", offset, off);
                check("ready_index", index, 127);
                if (x_q.size() == 0) check("x_queue_underflow", 1, 0);
                else check("x_value", x, x_q.pop_front());
            end
            if (busy && index != 7'd127) begin
                check("sweep_index", index, c - 2);
                if (c_q.size() == 0) check("coeff_queue_underflow", 1, 0);
                else check("coeff", coeff_mf, c_q.pop_front());
            end
            if (done) done_cyc = c;
            else begin
                step();
                c++;
            end
        end
        step();
        sample_tick = 1'b0;
        tpl_we      = 1'b0;
        check("done_cycle", done_cyc, 130);
        check("done_pulse", done, 0);
        check("queues_empty", x_q.size() + c_q.size(), 0);
        off = (off + 1) % 128;
        check("offset_after", offset, off);
        x_q.delete();
        c_q.delete();
    endtask

    initial begin
        int guard;
        int done_seen;
        reset       = 1'b1;
        sample_tick = 1'b0;
        x_in        = '0;
        tpl_we      = 1'b0;
        tpl_addr    = '0;
        tpl_data    = '0;
        step();
        step();
        check_reset_state();
        reset = 1'b0;
        step();
        check_reset_state();

        // Template load template[i] = i - 64
        for (int i = 0; i < 128; i++) begin
            model[i] = 9'(i - 64);
            tpl_we   = 1'b1;
            tpl_addr = 7'(i);
            tpl_data = model[i];
            step();
            tpl_we = 1'b0;
            check("load_ack", tpl_ack, 1);
            step();
            check("load_ack_pulse", tpl_ack, 0);
        end
        check("idle_coeff127", coeff_mf, 63);

        // Basic sweep
        sweep(9'sd25, -1, 0, 9'sd0, 1'b0, 7'd0, 9'sd0);
        check("overrun_clean", overrun, 0);

        // Tick dropped mid-sweep
        sweep(-9'sd100, 50, 0, 9'sd11, 1'b0, 7'd0, 9'sd0);
        check("overrun_set", overrun, 1);
        step();
        check("overrun_sticky", overrun, 1);

        // Write while busy is ignored, then the old value is still swept
        sweep(9'sd3, 60, 1, 9'sd3, 1'b0, 7'd5, -9'sd7);
        repeat (3) step();
        sweep(9'sd4, -1, 0, 9'sd0, 1'b0, 7'd0, 9'sd0);

        // Write in idle is accepted and used
        model[5] = -9'sd7;
        tpl_we   = 1'b1;
        tpl_addr = 7'd5;
        tpl_data = -9'sd7;
        step();
        tpl_we = 1'b0;
        check("idle_write_ack", tpl_ack, 1);
        step();
        sweep(-9'sd9, -1, 0, 9'sd0, 1'b0, 7'd0, 9'sd0);

        // Write coincident with tick
        step();
        sweep(9'sd1, -1, 0, 9'sd0, 1'b1, 7'd10, 9'sd33);

        // Tick coincident with drain exit
        do_reset();
        sweep(9'sd12, 130, 0, 9'sd77, 1'b0, 7'd0, 9'sd0);
        check("chain_ready", ready, 1);
        check("chain_x", x, 77);
        check("chain_overrun", overrun, 0);

        // Reset in the middle of the chained sweep
        guard = 0;
        while (index != 7'd60 && guard < 200) begin
            step();
            guard++;
        end
        check("reach_index60", index, 60);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_index", index, 127);
        check("abort_busy", busy, 0);
        check("abort_offset", offset, 0);
        check("abort_done", done, 0);
        off       = 0;
        done_seen = 0;
        for (int i = 0; i < 140; i++) begin
            if (done) done_seen = 1;
            step();
        end
        check("no_done_after_abort", done_seen, 0);
        sweep(9'sd5, -1, 0, 9'sd0, 1'b0, 7'd0, 9'sd0);

        // 128 back-to-back sweeps spaced 140 cycles
        do_reset();
        for (int s = 0; s < 128; s++) begin
            sweep(9'(s), -1, 0, 9'sd0, 1'b0, 7'd0, 9'sd0);
            repeat (8) step();
        end
        check("wrap_offset", offset, 0);
        check("wrap_overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
